modular_multiplier_rk: RTL
==========================

MODULAR_MULTIPLIER_RK -- requirements
Module: modular_multiplier_rk

Interface
REQ-001 Parameter N, default 1024, operand and result width in bits.
REQ-002 Parameter K, default 2, multiplier digit width (radix 2^K); N SHALL be a multiple of K, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 X  input  N  multiplier operand.
REQ-006 Y  input  N  multiplicand operand, required less than M.
REQ-007 M  input  N  modulus.
REQ-008 in_valid  input  1  operands valid.
REQ-009 in_ready  output  1  block can accept operands.
REQ-010 P  output  N  result X*Y mod M.
REQ-011 err  output  1  operand error flag, qualified by out_valid.
REQ-012 out_valid  output  1  P and err valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  operation in progress (any state other than IDLE).

Function
REQ-015 Each accepted operand set SHALL produce exactly one result, with P = (X*Y) mod M and P < M.
REQ-016 States SHALL be IDLE, CHECK, ACCUM, REDUCE and DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 captures X, Y and M into internal registers, clears the accumulator and sets the digit counter to N/K-1; next state CHECK.
REQ-018 CHECK: if M==0 or Y>=M, set err=1, force P=0 and go to DONE; otherwise go to ACCUM.
REQ-019 ACCUM: acc <= (acc<<K) + d*Y, where d is the K-bit digit of X at the counter position, taken MSB-first; next state REDUCE.
REQ-020 REDUCE: if acc>=M, acc <= acc-M and stay in REDUCE; otherwise, if counter==0 go to DONE, else decrement the counter and go to ACCUM.
REQ-021 The accumulator SHALL be N+K+1 bits wide, with no overflow or truncation at any step.
REQ-022 At most 2^(K+1)-1 subtractions SHALL occur per digit.
REQ-023 Total latency from accept to out_valid SHALL be at most 1 + N/K*(2^(K+1)+1) cycles.
REQ-024 DONE: out_valid=1 with P and err held stable until out_ready=1; the handshake cycle returns the block to IDLE.
REQ-025 in_ready SHALL be 0 in every state except IDLE, and operands presented while not ready SHALL be ignored.
REQ-026 Input operand changes after capture SHALL NOT affect the result.
REQ-027 X==0 SHALL give P=0; M==1 SHALL give P=0 with err=0.

Reset
REQ-028 Asserting n_reset SHALL immediately force IDLE, P=0, err=0, out_valid=0, busy=0, counter=0 and accumulator=0, including mid-operation.
REQ-029 An operation aborted by reset SHALL produce no result.
REQ-030 After reset deassertion the block SHALL accept new operands in the first IDLE cycle.

Structure
REQ-031 The state enum typedef SHALL reside in shared package modmul_pkg.
REQ-032 The accumulator, operand registers and subtractor SHALL form one sub-module, modmul_rk_datapath, driven by the FSM through load, accumulate and subtract strobes.

Verification
REQ-033 N=8, K=2: X=7, Y=5, M=11 -> P=2, err=0, within the latency bound of REQ-023.
REQ-034 N=8, K=2: X=255, Y=250, M=251 -> P=((255*250) mod 251)=247, err=0.
REQ-035 M=0, then Y=12 with M=11 -> err=1 and P=0 for each, with out_valid raised 2 cycles after accept.
REQ-036 out_ready held low for 5 cycles in DONE -> P, err and out_valid stable, in_ready=0; one cycle after out_ready=1 -> in_ready=1.
REQ-037 n_reset pulsed low during ACCUM -> outputs reset asynchronously, no result emitted, and the next operand set (X=3, Y=4, M=5) -> P=2.
REQ-038 Random N=64, K in {1,2,4} against a reference model, 10000 vectors with random out_ready backpressure -> all results match and P<M.

Source files
------------

// File: rtl/modmul_pkg.sv
// Shared types for the radix-2^K modular multiplier: controller state encoding
// and small elaboration-time helpers.
package modmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ACCUM,
    ST_REDUCE,
    ST_DONE
  } state_t;

  // Width of a down-counter that must hold values 0 .. digits-1 (at least 1 bit).
  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/modmul_rk_datapath.sv
// Operand registers, N+K+1-bit accumulator and modulus subtractor for the
// radix-2^K interleaved modular multiplier; sequenced by strobes from the FSM.
module modmul_rk_datapath
  import modmul_pkg::*;
#(
  parameter int N = 1024,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic         accumulate,
  input  logic         subtract,
  input  logic         finish,
  input  logic         fail,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  input  logic [N-1:0] m_in,
  output logic         acc_ge_m,
  output logic         op_err,
  output logic [N-1:0] p,
  output logic         err
);

  localparam int AW = N + K + 1;

  logic [N-1:0]  x_sh;
  logic [N-1:0]  y_r;
  logic [N-1:0]  m_r;
  logic [AW-1:0] acc;
  logic [AW-1:0] y_ext;
  logic [AW-1:0] m_ext;
  logic [AW-1:0] dy;
  logic [AW-1:0] acc_next;
  logic [K-1:0]  digit;

  // X is shifted left once per digit, so the current digit is always the top K bits.
  assign digit = x_sh[N-1 -: K];
  assign y_ext = {{(K+1){1'b0}}, y_r};
  assign m_ext = {{(K+1){1'b0}}, m_r};

  // d*Y as a sum of shifted copies of Y selected by the digit bits.
  always_comb begin
    dy = '0;
    for (int i = 0; i < K; i++) begin
      if (digit[i]) begin
        dy = dy + (y_ext << i);
      end
    end
  end

  // acc < M < 2^N on entry, so the shift never loses bits and the sum fits AW bits.
  assign acc_next = (acc << K) + dy;
  assign acc_ge_m = (acc >= m_ext);
  assign op_err   = (m_r == '0) || (y_r >= m_r);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      x_sh <= '0;
      y_r  <= '0;
      m_r  <= '0;
      acc  <= '0;
      p    <= '0;
      err  <= 1'b0;
    end else if (load) begin
      x_sh <= x_in;
      y_r  <= y_in;
      m_r  <= m_in;
      acc  <= '0;
      p    <= '0;
      err  <= 1'b0;
    end else begin
      if (accumulate) begin
        acc  <= acc_next;
        x_sh <= x_sh << K;
      end else if (subtract) begin
        acc <= acc - m_ext;
      end
      if (fail) begin
        p   <= '0;
        err <= 1'b1;
      end else if (finish) begin
        p   <= acc[N-1:0];
        err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/modular_multiplier_rk.sv
// Radix-2^K interleaved modular multiplier P = X*Y mod M with a valid/ready
// front end and a held result until the consumer accepts it.
module modular_multiplier_rk
  import modmul_pkg::*;
#(
  parameter int N = 1024,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic [N-1:0] M,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] P,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int DIGITS = N / K;
  localparam int CW     = cnt_width(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  if ((K < 1) || ((N % K) != 0)) begin : g_bad_digit_width
    $error("modular_multiplier_rk: N (%0d) must be a positive multiple of K (%0d)", N, K);
  end

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          load;
  logic          accumulate;
  logic          subtract;
  logic          finish;
  logic          fail;
  logic          cnt_dec;
  logic          acc_ge_m;
  logic          op_err;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= CNT_LAST;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    accumulate = 1'b0;
    subtract   = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (op_err) begin
          fail    = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        accumulate = 1'b1;
        state_d    = ST_REDUCE;
      end
      ST_REDUCE: begin
        // Stay here subtracting M until the partial result is fully reduced.
        if (acc_ge_m) begin
          subtract = 1'b1;
        end else if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  modmul_rk_datapath #(
    .N (N),
    .K (K)
  ) u_datapath (
    .clk        (clk),
    .n_reset    (n_reset),
    .load       (load),
    .accumulate (accumulate),
    .subtract   (subtract),
    .finish     (finish),
    .fail       (fail),
    .x_in       (X),
    .y_in       (Y),
    .m_in       (M),
    .acc_ge_m   (acc_ge_m),
    .op_err     (op_err),
    .p          (P),
    .err        (err)
  );

endmodule
